// File: rtl/fp_compare_pipe.sv
// Pipelined NaN-aware IEEE-754 compare/min/max (FEQ/FLT/FLE/FMIN/FMAX, SP and DP)
// with a valid/ready handshake. Define FPCMP_CLASS_EN to add FCLASS on OP=101.
module fp_compare_pipe #(
  parameter int unsigned STAGES     = 2,
  parameter int unsigned TAG_W      = 5,
  parameter bit          SUPPORT_DP = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [63:0]      INPUT_1,
  input  logic [63:0]      INPUT_2,
  input  logic             SP_DP,
  input  logic [2:0]       OP,
  input  logic [TAG_W-1:0] TAG_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [63:0]      RESULT,
  output logic             FLAG_NV,
  output logic [TAG_W-1:0] TAG_OUT,
  output logic             BUSY
);

  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [2:0] {
    OP_FEQ    = 3'b000,
    OP_FLT    = 3'b001,
    OP_FLE    = 3'b010,
    OP_FMIN   = 3'b011,
    OP_FMAX   = 3'b100,
    OP_FCLASS = 3'b101
  } op_e;

  typedef struct packed {
    logic        sign;
    logic [62:0] mag;   // exponent:mantissa, orders like an unsigned integer
    logic [63:0] val;   // SP values zero-extended so equality works for both widths
    logic        nan;
    logic        snan;
    logic        zero;
    logic [9:0]  cls;
  } operand_t;

  function automatic operand_t unpack_op(input logic [63:0] raw, input logic dp);
    operand_t o;
    logic [31:0] sp;
    logic exp_ones, exp_zero, man_zero, quiet, inf, sub, norm;
    o  = '0;
    // Improperly NaN-boxed SP operands read as the canonical quiet NaN.
    sp = (raw[63:32] == 32'hFFFF_FFFF) ? raw[31:0] : SP_QNAN;
    if (dp) begin
      o.val    = raw;
      o.sign   = raw[63];
      o.mag    = raw[62:0];
      exp_ones = &raw[62:52];
      exp_zero = ~|raw[62:52];
      man_zero = ~|raw[51:0];
      quiet    = raw[51];
    end else begin
      o.val    = {32'h0, sp};
      o.sign   = sp[31];
      o.mag    = {32'h0, sp[30:0]};
      exp_ones = &sp[30:23];
      exp_zero = ~|sp[30:23];
      man_zero = ~|sp[22:0];
      quiet    = sp[22];
    end
    o.nan  = exp_ones & ~man_zero;
    o.snan = o.nan & ~quiet;
    o.zero = exp_zero & man_zero;
    inf    = exp_ones & man_zero;
    sub    = exp_zero & ~man_zero;
    norm   = ~exp_ones & ~exp_zero;
    o.cls  = {o.nan & quiet, o.snan,
              ~o.sign & inf, ~o.sign & norm, ~o.sign & sub, ~o.sign & o.zero,
              o.sign & o.zero, o.sign & sub, o.sign & norm, o.sign & inf};
    return o;
  endfunction

  logic        w_dp;
  operand_t    w_a, w_b;
  logic        w_any_nan, w_any_snan, w_both_zero;
  logic        w_lt_total, w_lt, w_eq;
  logic [63:0] w_minmax;
  logic [63:0] w_res;
  logic        w_nv;
  logic        w_unused_cls;

  assign w_dp = SUPPORT_DP && SP_DP;
  assign w_a  = unpack_op(INPUT_1, w_dp);
  assign w_b  = unpack_op(INPUT_2, w_dp);
  assign w_unused_cls = ^{w_a.cls, w_b.cls};

  always_comb begin
    w_any_nan   = w_a.nan | w_b.nan;
    w_any_snan  = w_a.snan | w_b.snan;
    w_both_zero = w_a.zero & w_b.zero;
    // Total order with -0 < +0; FLT/FLE mask the signed-zero case out below.
    if (w_a.sign != w_b.sign) w_lt_total = w_a.sign;
    else if (w_a.sign)        w_lt_total = w_a.mag > w_b.mag;
    else                      w_lt_total = w_a.mag < w_b.mag;
    w_lt = w_lt_total & ~w_both_zero;
    w_eq = w_both_zero | (w_a.val == w_b.val);

    if (w_a.nan & w_b.nan)                 w_minmax = w_dp ? DP_QNAN : {32'h0, SP_QNAN};
    else if (w_a.nan)                      w_minmax = w_b.val;
    else if (w_b.nan)                      w_minmax = w_a.val;
    else if (w_lt_total ^ (OP == OP_FMAX)) w_minmax = w_a.val;
    else                                   w_minmax = w_b.val;
    if (!w_dp) w_minmax[63:32] = 32'hFFFF_FFFF;

    w_res = '0;
    w_nv  = 1'b0;
    case (op_e'(OP))
      OP_FEQ: begin
        w_res[0] = ~w_any_nan & w_eq;
        w_nv     = w_any_snan;
      end
      OP_FLT: begin
        w_res[0] = ~w_any_nan & w_lt;
        w_nv     = w_any_nan;
      end
      OP_FLE: begin
        w_res[0] = ~w_any_nan & (w_lt | w_eq);
        w_nv     = w_any_nan;
      end
      OP_FMIN, OP_FMAX: begin
        w_res = w_minmax;
        w_nv  = w_any_snan;
      end
`ifdef FPCMP_CLASS_EN
      OP_FCLASS: w_res[9:0] = w_a.cls;
`endif
      default: ;
    endcase
  end

  // Pipeline: stage k loads when empty or when stage k+1 takes its contents.
  logic [STAGES-1:0] r_valid;
  logic [63:0]       r_result [STAGES];
  logic [STAGES-1:0] r_nv;
  logic [TAG_W-1:0]  r_tag    [STAGES];

  logic [STAGES-1:0] w_load;
  logic [STAGES-1:0] w_src_valid;
  logic [63:0]       w_src_result [STAGES];
  logic [STAGES-1:0] w_src_nv;
  logic [TAG_W-1:0]  w_src_tag    [STAGES];

  always_comb begin
    w_load = '0;
    w_load[STAGES-1] = ~r_valid[STAGES-1] | OUT_READY;
    for (int k = STAGES - 2; k >= 0; k--) begin
      w_load[k] = ~r_valid[k] | w_load[k+1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_first
      assign w_src_valid[g]  = IN_VALID;
      assign w_src_result[g] = w_res;
      assign w_src_nv[g]     = w_nv;
      assign w_src_tag[g]    = TAG_IN;
    end else begin : g_next
      assign w_src_valid[g]  = r_valid[g-1];
      assign w_src_result[g] = r_result[g-1];
      assign w_src_nv[g]     = r_nv[g-1];
      assign w_src_tag[g]    = r_tag[g-1];
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < STAGES; k++) begin
      // NOTE: payload registers are reset too, because RESULT/FLAG_NV/TAG_OUT must read 0 after reset.
      if (RST) begin
        r_valid[k]  <= 1'b0;
        r_result[k] <= '0;
        r_nv[k]     <= 1'b0;
        r_tag[k]    <= '0;
      end else if (w_load[k]) begin
        r_valid[k] <= w_src_valid[k];
        // Payload only moves with a valid op, so bubbles never disturb held outputs.
        if (w_src_valid[k]) begin
          r_result[k] <= w_src_result[k];
          r_nv[k]     <= w_src_nv[k];
          r_tag[k]    <= w_src_tag[k];
        end
      end
    end
  end

  assign IN_READY  = w_load[0];
  assign OUT_VALID = r_valid[STAGES-1];
  assign RESULT    = r_result[STAGES-1];
  assign FLAG_NV   = r_nv[STAGES-1];
  assign TAG_OUT   = r_tag[STAGES-1];
  assign BUSY      = |r_valid;

endmodule

// File: tb/tb_fp_compare_pipe.sv
// Directed self-checking bench for fp_compare_pipe: IEEE compare/min/max vectors,
// latency, back-pressure ordering and reset flush.
module tb_fp_compare_pipe;

  localparam int STAGES = 2;
  localparam int TAG_W  = 5;

  localparam logic [2:0] FEQ = 3'b000, FLT = 3'b001, FLE = 3'b010,
                         FMIN = 3'b011, FMAX = 3'b100, FCLS = 3'b101, ILL = 3'b111;
  localparam logic [31:0] BOX = 32'hFFFF_FFFF;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             IN_VALID = 1'b0;
  logic             IN_READY;
  logic [63:0]      INPUT_1 = '0;
  logic [63:0]      INPUT_2 = '0;
  logic             SP_DP = 1'b0;
  logic [2:0]       OP = '0;
  logic [TAG_W-1:0] TAG_IN = '0;
  logic             OUT_VALID;
  logic             OUT_READY = 1'b1;
  logic [63:0]      RESULT;
  logic             FLAG_NV;
  logic [TAG_W-1:0] TAG_OUT;
  logic             BUSY;

  fp_compare_pipe #(.STAGES(STAGES), .TAG_W(TAG_W), .SUPPORT_DP(1'b1)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .INPUT_1(INPUT_1), .INPUT_2(INPUT_2), .SP_DP(SP_DP), .OP(OP), .TAG_IN(TAG_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RESULT(RESULT), .FLAG_NV(FLAG_NV),
    .TAG_OUT(TAG_OUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;
  bit mon_en = 1'b0;
  logic [TAG_W-1:0] q_tag[$];
  logic [63:0]      q_res[$];
  int               q_cyc[$];

  always @(posedge CLK) cycle++;

  // Outputs are stable between negedge and the next posedge, where the transfer happens.
  always @(negedge CLK) begin
    if (mon_en && !RST && OUT_VALID && OUT_READY) begin
      q_tag.push_back(TAG_OUT);
      q_res.push_back(RESULT);
      q_cyc.push_back(cycle);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one op and return #1 after the edge that accepted it.
  task automatic send(input logic dp, input logic [2:0] op, input logic [63:0] a,
                      input logic [63:0] b, input logic [TAG_W-1:0] tag);
    bit ok;
    int waited;
    SP_DP = dp; OP = op; INPUT_1 = a; INPUT_2 = b; TAG_IN = tag; IN_VALID = 1'b1;
    ok = 1'b0;
    waited = 0;
    do begin
      #1 ok = IN_READY;
      @(posedge CLK);
      #1 waited++;
    end while (!ok && waited < 50);
    IN_VALID = 1'b0;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input string name, input logic dp, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] tag,
                        input logic [63:0] exp_res, input logic exp_nv);
    int lat;
    send(dp, op, a, b, tag);
    lat = 1;
    while (!OUT_VALID && lat < 20) begin
      @(posedge CLK);
      #1 lat++;
    end
    check({name, " latency"}, 64'(lat), 64'(STAGES));
    check({name, " result"}, RESULT, exp_res);
    check({name, " nv"}, 64'(FLAG_NV), 64'(exp_nv));
    check({name, " tag"}, 64'(TAG_OUT), 64'(tag));
  endtask

  logic [63:0] exp_cls;
  logic [63:0] exp_bp [4];

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    check("rst out_valid", 64'(OUT_VALID), 64'd0);
    check("rst result", RESULT, 64'd0);
    check("rst nv", 64'(FLAG_NV), 64'd0);
    check("rst tag", 64'(TAG_OUT), 64'd0);
    check("rst busy", 64'(BUSY), 64'd0);
    RST = 1'b0;
    #1 check("rst in_ready", 64'(IN_READY), 64'd1);
    @(posedge CLK);
    #1;

    run_op("sp flt -1<1", 0, FLT, {BOX, 32'hBF80_0000}, {BOX, 32'h3F80_0000}, 5'd1, 64'd1, 0);
    run_op("dp feq -0=+0", 1, FEQ, 64'h8000_0000_0000_0000, 64'd0, 5'd2, 64'd1, 0);
    run_op("dp fmin -0,+0", 1, FMIN, 64'h8000_0000_0000_0000, 64'd0, 5'd3,
           64'h8000_0000_0000_0000, 0);
    run_op("sp fle qnan", 0, FLE, {BOX, 32'h3F80_0000}, {BOX, 32'h7FC0_0000}, 5'd4, 64'd0, 1);
    run_op("sp feq qnan", 0, FEQ, {BOX, 32'h3F80_0000}, {BOX, 32'h7FC0_0000}, 5'd5, 64'd0, 0);
    run_op("sp feq snan", 0, FEQ, {BOX, 32'h3F80_0000}, {BOX, 32'h7F80_0001}, 5'd6, 64'd0, 1);
    run_op("dp fmax 2snan", 1, FMAX, 64'h7FF0_0000_0000_0001, 64'h7FF0_0000_0000_0001, 5'd7,
           64'h7FF8_0000_0000_0000, 1);
    run_op("sp fmax badbox", 0, FMAX, 64'h0000_0000_4000_0000, {BOX, 32'h3F80_0000}, 5'd8,
           {BOX, 32'h3F80_0000}, 0);
    run_op("sp flt -0,+0", 0, FLT, {BOX, 32'h8000_0000}, {BOX, 32'h0000_0000}, 5'd9, 64'd0, 0);
    run_op("sp fle -0,+0", 0, FLE, {BOX, 32'h8000_0000}, {BOX, 32'h0000_0000}, 5'd10, 64'd1, 0);
    run_op("sp fle 2=2", 0, FLE, {BOX, 32'h4000_0000}, {BOX, 32'h4000_0000}, 5'd11, 64'd1, 0);
    run_op("dp flt 2<-3", 1, FLT, 64'h4000_0000_0000_0000, 64'hC008_0000_0000_0000, 5'd12, 64'd0, 0);
    run_op("dp flt -3<-2", 1, FLT, 64'hC008_0000_0000_0000, 64'hC000_0000_0000_0000, 5'd13, 64'd1, 0);
    run_op("dp fmax 1,2", 1, FMAX, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd14,
           64'h4000_0000_0000_0000, 0);
    run_op("sp fmin qnan,2", 0, FMIN, {BOX, 32'h7FC0_0000}, {BOX, 32'h4000_0000}, 5'd15,
           {BOX, 32'h4000_0000}, 0);
    run_op("sp fmin 2nan", 0, FMIN, {BOX, 32'h7FC0_0000}, {BOX, 32'h7F80_0001}, 5'd16,
           {BOX, 32'h7FC0_0000}, 1);
    run_op("dp illegal op", 1, ILL, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 5'd17, 64'd0, 0);
`ifdef FPCMP_CLASS_EN
    exp_cls = 64'h40;
`else
    exp_cls = 64'h0;
`endif
    run_op("sp op101", 0, FCLS, {BOX, 32'h3F80_0000}, {BOX, 32'h0000_0000}, 5'd18, exp_cls, 0);
    @(posedge CLK);
    #1;

    // Back-pressure: fill the pipe, stall, then drain in order.
    exp_bp[0] = {BOX, 32'hBF80_0000};
    exp_bp[1] = 64'd1;
    exp_bp[2] = 64'h4000_0000_0000_0000;
    exp_bp[3] = 64'd1;
    q_tag.delete(); q_res.delete(); q_cyc.delete();
    mon_en = 1'b1;
    OUT_READY = 1'b0;
    send(0, FMIN, {BOX, 32'hBF80_0000}, {BOX, 32'h3F80_0000}, 5'd1);
    send(0, FLT, {BOX, 32'hBF80_0000}, {BOX, 32'h3F80_0000}, 5'd2);
    SP_DP = 1'b1; OP = FMAX; INPUT_1 = 64'h3FF0_0000_0000_0000;
    INPUT_2 = 64'h4000_0000_0000_0000; TAG_IN = 5'd3; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall in_ready", 64'(IN_READY), 64'd0);
      check("stall tag", 64'(TAG_OUT), 64'd1);
      check("stall result", RESULT, exp_bp[0]);
      @(posedge CLK);
      #1;
    end
    OUT_READY = 1'b1;
    send(1, FMAX, 64'h3FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 5'd3);
    send(0, FEQ, {BOX, 32'h3F80_0000}, {BOX, 32'h3F80_0000}, 5'd4);
    repeat (6) @(posedge CLK);
    #1;
    check("bp count", 64'(q_tag.size()), 64'd4);
    for (int i = 0; i < q_tag.size() && i < 4; i++) begin
      check($sformatf("bp tag[%0d]", i), 64'(q_tag[i]), 64'(i + 1));
      check($sformatf("bp res[%0d]", i), q_res[i], exp_bp[i]);
      if (i > 0) check($sformatf("bp spacing[%0d]", i), 64'(q_cyc[i] - q_cyc[i-1]), 64'd1);
    end

    // Reset with two ops in flight: nothing may emerge afterwards.
    q_tag.delete(); q_res.delete(); q_cyc.delete();
    OUT_READY = 1'b0;
    send(0, FEQ, {BOX, 32'h3F80_0000}, {BOX, 32'h3F80_0000}, 5'd7);
    send(0, FEQ, {BOX, 32'h3F80_0000}, {BOX, 32'h3F80_0000}, 5'd8);
    RST = 1'b1;
    @(posedge CLK);
    #1;
    check("flush out_valid", 64'(OUT_VALID), 64'd0);
    check("flush busy", 64'(BUSY), 64'd0);
    RST = 1'b0;
    OUT_READY = 1'b1;
    #1 check("flush in_ready", 64'(IN_READY), 64'd1);
    repeat (5) @(posedge CLK);
    #1;
    check("flush no stale", 64'(q_tag.size()), 64'd0);
    check("flush idle", 64'(OUT_VALID), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
